// File: rtl/risc_pkg.sv
// Shared RV32I core definitions: fetch FSM states and fetch-queue constants.
package risc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int unsigned FETCH_Q_DEPTH = 2;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} between instruction memory and decode.
module fetch_queue
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        pop,
  input  logic        flush,
  output logic [1:0]  count,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr
);

  logic [31:0] r_pc    [FETCH_Q_DEPTH];
  logic [31:0] r_instr [FETCH_Q_DEPTH];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
      for (int unsigned i = 0; i < FETCH_Q_DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_pc[r_wptr]    <= push_pc;
        r_instr[r_wptr] <= push_instr;
        r_wptr          <= ~r_wptr;
      end
      if (pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count      = r_count;
  assign head_valid = (r_count != 2'd0);
  assign head_pc    = head_valid ? r_pc[r_rptr]    : '0;
  assign head_instr = head_valid ? r_instr[r_rptr] : NOP_INSTR;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC register, single-outstanding imem issue FSM and
// redirect handling in front of a 2-entry instruction queue.
module fetch_unit
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] target_pc
);

  fetch_state_e r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_req_pc;

  logic         w_retire;
  logic         w_redir;
  logic         w_accept;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_qcount;

  assign w_retire = instr_valid & instr_ready;
  assign w_redir  = w_retire & (branch_taken | jump);
  // rst gate keeps the request low during reset even though state reads IDLE.
  assign imem_req = ~rst & (r_state == IDLE) & (w_qcount < 2'(FETCH_Q_DEPTH)) & ~w_redir;
  assign w_accept = imem_req & imem_ready;
  assign w_push   = (r_state == BUSY) & imem_rvalid & ~w_redir;
  assign w_pop    = w_retire & ~w_redir;
  assign imem_addr = r_fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= BUSY;
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        BUSY: begin
          if (imem_rvalid) begin
            r_state <= IDLE;
          end else if (w_redir) begin
            r_state <= STALE;
          end
        end
        STALE: begin
          if (imem_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_redir) begin
        r_fetch_pc <= target_pc & 32'hFFFF_FFFC;
      end
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_pc    (r_req_pc),
    .push_instr (imem_rdata),
    .pop        (w_pop),
    .flush      (w_redir),
    .count      (w_qcount),
    .head_valid (instr_valid),
    .head_pc    (instr_pc),
    .head_instr (instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model and
// a variable-latency instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        branch_taken;
  logic        jump;
  logic [31:0] target_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .jump         (jump),
    .target_pc    (target_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a fetch pointer, outstanding/wrong-path flags, a queue.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_req_pc;
  bit          m_busy;
  bit          m_stale;

  // Memory model: one pending response counted down in cycles.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;

  task automatic model_reset();
    mq.delete();
    m_fpc    = RST_PC;
    m_req_pc = '0;
    m_busy   = 0;
    m_stale  = 0;
  endtask

  task automatic mem_edge(input bit acc);
    if (mem_busy) begin
      if (mem_cnt == 0) mem_busy = 0;
      else mem_cnt--;
    end
    if (acc) begin
      mem_busy = 1;
      mem_cnt  = $urandom_range(0, 2);
      mem_data = $urandom;
    end
  endtask

  task automatic drive_mem(input bit allow_ready);
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_data : $urandom;
    imem_ready  = allow_ready && !mem_busy && ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    drive_mem(0);
    #1;
    check_reset_outputs();
    @(posedge clk);
    mem_edge(0);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit          retire, redir, acc, rv, exp_req, exp_valid;
    logic [31:0] exp_instr, exp_pc;

    rst = 1'b1;
    instr_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0; target_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_busy = 0; mem_cnt = 0; mem_data = '0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      if (i == 400 || i == 800) begin
        do_reset();
      end else begin
        drive_mem(1);
        if (i < 60) begin
          instr_ready = 1'b1; branch_taken = 1'b0; jump = 1'b0;
        end else if (i < 80) begin
          instr_ready = 1'b0; branch_taken = $urandom_range(0, 1); jump = $urandom_range(0, 1);
        end else begin
          instr_ready  = ($urandom_range(0, 9) < 6);
          branch_taken = ($urandom_range(0, 7) == 0);
          jump         = ($urandom_range(0, 11) == 0);
        end
        target_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : ($urandom & 32'h0000_03FF);
        #1;

        exp_valid = (mq.size() != 0);
        exp_instr = exp_valid ? mq[0].ins : NOP;
        exp_pc    = exp_valid ? mq[0].pc  : 32'd0;
        retire    = exp_valid && instr_ready;
        redir     = retire && (branch_taken || jump);
        exp_req   = !m_busy && !m_stale && (mq.size() < 2) && !redir;
        acc       = exp_req && imem_ready;
        rv        = imem_rvalid;

        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check("imem_addr", imem_addr, m_fpc);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
        check("instr", instr, exp_instr);
        check("instr_pc", instr_pc, exp_pc);

        if (redir) begin
          mq.delete();
          if (m_stale && rv) m_stale = 0;
          if (m_busy && !rv) m_stale = 1;
          m_busy = 0;
          m_fpc  = target_pc & 32'hFFFF_FFFC;
        end else begin
          if (retire) void'(mq.pop_front());
          if (m_stale && rv) m_stale = 0;
          if (m_busy && rv) begin
            mq.push_back('{pc: m_req_pc, ins: imem_rdata});
            m_busy = 0;
          end
          if (acc) begin
            m_req_pc = m_fpc;
            m_fpc    = m_fpc + 32'd4;
            m_busy   = 1;
          end
        end

        @(posedge clk);
        mem_edge(acc);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core, directly upstream of decode/execute and the branch comparator. Holds the fetch PC, issues one-outstanding requests to instruction memory, and buffers returned words in a 2-entry queue presented to decode with valid/ready. It consumes the branch comparator's `branch_taken` (plus jump and target) on instruction retirement to redirect the PC and discard wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: request valid; `imem_addr` is valid while high.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_ready` in 1: request accepted when `imem_req & imem_ready`.
- `imem_rvalid` in 1: response valid, at least 1 cycle after acceptance; never back-pressured.
- `imem_rdata` in 32: instruction word.
- `instr_valid` out 1: queue head valid.
- `instr` out 32: queue head instruction.
- `instr_pc` out 32: PC of queue head.
- `instr_ready` in 1: decode consumes head when `instr_valid & instr_ready` (retire).
- `branch_taken` in 1: from branch comparator, already gated by B-type; sampled only on retire.
- `jump` in 1: JAL/JALR of retiring instruction.
- `target_pc` in 32: redirect target of retiring instruction.

## Operation
- Redirect `redir = instr_valid & instr_ready & (branch_taken | jump)`.
- FSM (3 states):
  - IDLE: nothing outstanding.
  - BUSY: one live request outstanding.
  - STALE: one outstanding request belonging to the wrong path.
- `imem_req = (state==IDLE) & (count<2) & ~redir`. It is combinational from `instr_ready`/`branch_taken`/`jump`; the memory must not accept while `imem_req` is low. Deassertion before acceptance is legal.
- `imem_addr = fetch_pc`.
- IDLE→BUSY on accept: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (mod 2^32, wraps 0xFFFF_FFFC→0).
- BUSY, `imem_rvalid`, no redir: push `{req_pc, imem_rdata}`, →IDLE.
- BUSY, redir without rvalid: →STALE. Redir with rvalid in the same cycle: response dropped, →IDLE.
- STALE, `imem_rvalid`: drop response, →IDLE.
- Redirect in any state:
  - Queue flushed (count←0).
  - `fetch_pc <= {target_pc[31:2], 2'b00}`; low bits are ignored, no misalign trap here.
  - No request is issued in the redirect cycle.
- Queue: 2-entry FIFO, push/pop pointers plus 2-bit count.
  - Push and pop in the same cycle are legal at count 1.
  - Push never occurs at count 2, guaranteed by the issue rule.
  - Redirect flush overrides a push in the same cycle.
- Empty queue outputs: `instr_valid=0`, `instr=32'h0000_0013` (NOP), `instr_pc=0`.
- `branch_taken`/`jump`/`target_pc` are don't-care unless retiring.

## Timing
- Reset (async assert, sync-released) sets:
  - state IDLE, `fetch_pc=RESET_PC`, count 0, pointers 0.
  - Outputs: `imem_req=0` while `rst` is high, `instr_valid=0`, `instr=NOP`, `instr_pc=0`.
- First cycle after release: `imem_req=1`, `imem_addr=RESET_PC`.
- Reset mid-request: outstanding and stale state are lost. Memory responses arriving after release while IDLE are ignored.
- Latency: acceptance at cycle N, rvalid at N+k (k≥1), then `instr_valid` at N+k+1.
- Best-case sustained rate is 1 instruction per 2 cycles, because the next request issues the cycle after the response returns.
- Redirect penalty with k=1:
  - At least 1 cycle from redirect to the target request.
  - Plus remaining wait if STALE.

## Structure
- `risc_pkg` additions:
  - `fetch_state_e` enum (IDLE/BUSY/STALE).
  - `NOP_INSTR = 32'h0000_0013`.
  - `FETCH_Q_DEPTH = 2`.
- Sub-module `fetch_queue`: 2-entry FIFO of {pc, instr} with push, pop, flush, count, and head outputs.
- `fetch_unit` contains the FSM, PC register and issue logic.

## Test plan
- Reset release, `imem_ready=1`, k=1, `instr_ready=1` → requests at 0x0, 0x4, 0x8. `instr_pc` sequence is 0x0, 0x4, 0x8 with matching rdata.
- `instr_ready=0` for 10 cycles → queue fills to 2 (PCs 0x0, 0x4). `imem_req` drops; no third request until a pop.
- Retire PC 0x4 with `branch_taken=1`, `target_pc=0x100` while request 0x8 is outstanding with k=3 → 0x8 response dropped, queue empty. Next request is 0x100, then `instr_pc=0x100`.
- Redirect in the same cycle as rvalid, `target_pc=0x203` → response dropped. Next `imem_addr=0x200`.
- `jump=1` with `branch_taken=0` redirects. `branch_taken=0`, `jump=0` gives sequential PC+4. Redirect inputs asserted while `instr_ready=0` are ignored.
- `RESET_PC=0xFFFF_FFFC` → second request address 0x0. Assert `rst` mid-BUSY → outputs reset immediately, refetch from `RESET_PC`.
